// File: rtl/fft_peak_search.sv
// Per-frame peak finder for the FFT magnitude stream: reports the largest magnitude within [SEARCH_LO, SEARCH_HI].
// Optional macro PEAK_NEIGHBOUR_EN adds the left/right neighbour magnitudes of the peak for interpolation.
module fft_peak_search #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int N_BINS    = 16384,
    parameter int SEARCH_LO = 2,
    parameter int SEARCH_HI = 8191
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_magni_valid,
    input  logic [DATA_W-1:0] s_magni_data,
    input  logic [ADDR_W-1:0] s_magni_addr,
    output logic              m_peak_tvalid,
    input  logic              m_peak_tready,
    output logic [ADDR_W-1:0] m_peak_bin,
    output logic [DATA_W-1:0] m_peak_mag,
    output logic [7:0]        m_frame_id,
    output logic              err_seq,
    output logic [7:0]        drop_cnt
`ifdef PEAK_NEIGHBOUR_EN
    ,
    output logic [DATA_W-1:0] m_peak_left,
    output logic [DATA_W-1:0] m_peak_right
`endif
);

    localparam logic [ADDR_W-1:0] LO_A   = ADDR_W'(SEARCH_LO);
    localparam logic [ADDR_W-1:0] HI_A   = ADDR_W'(SEARCH_HI);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_BINS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   exp_q, exp_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [ADDR_W-1:0]   bin_q, bin_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [7:0]          drop_q, drop_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   out_bin_q, out_bin_d;
    logic [DATA_W-1:0]   out_mag_q, out_mag_d;
    logic [7:0]          out_id_q, out_id_d;
`ifdef PEAK_NEIGHBOUR_EN
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic [DATA_W-1:0]   right_q, right_d;
    logic                need_right_q, need_right_d;
    logic [DATA_W-1:0]   out_left_q, out_left_d;
    logic [DATA_W-1:0]   out_right_q, out_right_d;
`endif

    logic in_win;
    logic is_zero;
    logic is_last;
    logic start;
    logic upd;

    assign in_win  = (s_magni_addr >= LO_A) && (s_magni_addr <= HI_A);
    assign is_zero = (s_magni_addr == '0);
    assign is_last = (s_magni_addr == LAST_A);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        max_d       = max_q;
        bin_d       = bin_q;
        frame_cnt_d = frame_cnt_q;
        drop_d      = drop_q;
        err_d       = 1'b0;
        out_bin_d   = out_bin_q;
        out_mag_d   = out_mag_q;
        out_id_d    = out_id_q;
        start       = 1'b0;
        upd         = 1'b0;
`ifdef PEAK_NEIGHBOUR_EN
        prev_d       = s_magni_valid ? s_magni_data : prev_q;
        left_d       = left_q;
        right_d      = right_q;
        need_right_d = need_right_q;
        out_left_d   = out_left_q;
        out_right_d  = out_right_q;
`endif

        case (state_q)
            IDLE: begin
                if (s_magni_valid && is_zero) begin
                    start = 1'b1;
                end
            end
            SCAN: begin
                if (s_magni_valid) begin
                    if (s_magni_addr != exp_q) begin
                        err_d = 1'b1;
                        if (is_zero) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        // Strict compare keeps the lowest bin on ties
                        upd   = in_win && (s_magni_data > max_q);
                        exp_d = exp_q + 1'b1;
                        if (upd) begin
                            max_d = s_magni_data;
                            bin_d = s_magni_addr;
                        end
`ifdef PEAK_NEIGHBOUR_EN
                        if (upd) begin
                            left_d       = prev_q;
                            need_right_d = 1'b1;
                        end else if (need_right_q) begin
                            right_d      = s_magni_data;
                            need_right_d = 1'b0;
                        end
`endif
                        if (is_last) begin
                            out_bin_d   = upd ? s_magni_addr : bin_q;
                            out_mag_d   = upd ? s_magni_data : max_q;
                            out_id_d    = frame_cnt_q;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            state_d     = HOLD;
`ifdef PEAK_NEIGHBOUR_EN
                            out_left_d  = upd ? prev_q : left_q;
                            out_right_d = need_right_q ? s_magni_data : right_q;
`endif
                        end
                    end
                end
            end
            HOLD: begin
                if (s_magni_valid && is_zero && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (m_peak_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: this beat is bin 0 of a fresh scan
        if (start) begin
            state_d = SCAN;
            exp_d   = {{(ADDR_W-1){1'b0}}, 1'b1};
            bin_d   = LO_A;
            upd     = in_win && (s_magni_data != '0);
            max_d   = upd ? s_magni_data : '0;
`ifdef PEAK_NEIGHBOUR_EN
            left_d       = '0;
            right_d      = '0;
            need_right_d = upd;
`endif
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            max_q       <= '0;
            bin_q       <= '0;
            frame_cnt_q <= '0;
            drop_q      <= '0;
            err_q       <= 1'b0;
            out_bin_q   <= '0;
            out_mag_q   <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            max_q       <= max_d;
            bin_q       <= bin_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            out_bin_q   <= out_bin_d;
            out_mag_q   <= out_mag_d;
            out_id_q    <= out_id_d;
        end
    end

`ifdef PEAK_NEIGHBOUR_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_q       <= '0;
            left_q       <= '0;
            right_q      <= '0;
            need_right_q <= 1'b0;
            out_left_q   <= '0;
            out_right_q  <= '0;
        end else begin
            prev_q       <= prev_d;
            left_q       <= left_d;
            right_q      <= right_d;
            need_right_q <= need_right_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
        end
    end

    assign m_peak_left  = out_left_q;
    assign m_peak_right = out_right_q;
`endif

    assign m_peak_tvalid = (state_q == HOLD);
    assign m_peak_bin    = out_bin_q;
    assign m_peak_mag    = out_mag_q;
    assign m_frame_id    = out_id_q;
    assign err_seq       = err_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_fft_peak_search.sv
// Scoreboard bench for fft_peak_search using a shortened 2048-bin frame (window 2..1023).
module tb_fft_peak_search;

    localparam int NB = 2048;
    localparam int LO = 2;
    localparam int HI = 1023;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_magni_valid = 1'b0;
    logic [15:0] s_magni_data = '0;
    logic [15:0] s_magni_addr = '0;
    logic        m_peak_tvalid;
    logic        m_peak_tready = 1'b1;
    logic [15:0] m_peak_bin;
    logic [15:0] m_peak_mag;
    logic [7:0]  m_frame_id;
    logic        err_seq;
    logic [7:0]  drop_cnt;
`ifdef PEAK_NEIGHBOUR_EN
    logic [15:0] m_peak_left;
    logic [15:0] m_peak_right;
`endif

    fft_peak_search #(
        .DATA_W(16), .ADDR_W(16), .N_BINS(NB), .SEARCH_LO(LO), .SEARCH_HI(HI)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_magni_valid(s_magni_valid), .s_magni_data(s_magni_data), .s_magni_addr(s_magni_addr),
        .m_peak_tvalid(m_peak_tvalid), .m_peak_tready(m_peak_tready),
        .m_peak_bin(m_peak_bin), .m_peak_mag(m_peak_mag), .m_frame_id(m_frame_id),
        .err_seq(err_seq), .drop_cnt(drop_cnt)
`ifdef PEAK_NEIGHBOUR_EN
        , .m_peak_left(m_peak_left), .m_peak_right(m_peak_right)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int bin; int mag; int id; int left; int right;
    } exp_t;

    exp_t sb[$];
    int   mem[NB];
    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NB; i++) mem[i] = v;
    endtask

    task automatic push(input int b, input int m, input int id, input int l, input int r);
        exp_t e;
        e.bin = b; e.mag = m; e.id = id; e.left = l; e.right = r;
        sb.push_back(e);
        $display("issue: expect bin=%0d mag=%0d id=%0d left=%0d right=%0d", b, m, id, l, r);
    endtask

    task automatic stream(input int a0, input int a1);
        for (int a = a0; a <= a1; a++) begin
            @(posedge aclk); #1;
            s_magni_valid = 1'b1;
            s_magni_addr  = 16'(a);
            s_magni_data  = 16'(mem[a]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
            s_magni_valid = 1'b0;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " tvalid"}, int'(m_peak_tvalid), 0);
        chk({tag, " bin"}, int'(m_peak_bin), 0);
        chk({tag, " mag"}, int'(m_peak_mag), 0);
        chk({tag, " frame_id"}, int'(m_frame_id), 0);
        chk({tag, " err_seq"}, int'(err_seq), 0);
        chk({tag, " drop_cnt"}, int'(drop_cnt), 0);
`ifdef PEAK_NEIGHBOUR_EN
        chk({tag, " left"}, int'(m_peak_left), 0);
        chk({tag, " right"}, int'(m_peak_right), 0);
`endif
    endtask

    // Monitor: every cycle with a valid result is compared to the queue head, so a held result must stay stable
    always @(negedge aclk) begin
        if (aresetn) begin
            if (err_seq) err_seen++;
            if (m_peak_tvalid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got bin=%0d mag=%0d id=%0d, none expected",
                             m_peak_bin, m_peak_mag, m_frame_id);
                end else begin
                    int l; int r;
                    l = sb[0].left; r = sb[0].right;
`ifdef PEAK_NEIGHBOUR_EN
                    l = int'(m_peak_left); r = int'(m_peak_right);
`endif
                    if (int'(m_peak_bin) != sb[0].bin || int'(m_peak_mag) != sb[0].mag ||
                        int'(m_frame_id) != sb[0].id || l != sb[0].left || r != sb[0].right) begin
                        errors++;
                        $display("FAIL peak_result: got bin=%0d mag=%0d id=%0d left=%0d right=%0d expected bin=%0d mag=%0d id=%0d left=%0d right=%0d",
                                 m_peak_bin, m_peak_mag, m_frame_id, l, r,
                                 sb[0].bin, sb[0].mag, sb[0].id, sb[0].left, sb[0].right);
                    end
                    if (m_peak_tready) begin
                        $display("handshake: bin=%0d mag=%0d id=%0d", m_peak_bin, m_peak_mag, m_frame_id);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        repeat (3) @(posedge aclk);
        #1;
        chk_zero_outputs("reset");
        aresetn = 1'b1;
        idle(2);

        // Single dominant bin
        fill(10); mem[1000] = 500;
        push(1000, 500, 0, 10, 10);
        stream(0, NB-1); idle(3);

        // DC, bin 1 and upper half excluded
        fill(0); mem[0] = 60000; mem[1] = 50000; mem[1500] = 40000; mem[300] = 20;
        push(300, 20, 1, 0, 0);
        stream(0, NB-1); idle(3);

        // Tie keeps the lowest bin
        fill(1); mem[50] = 700; mem[900] = 700; mem[49] = 3; mem[51] = 9;
        push(50, 700, 2, 3, 9);
        stream(0, NB-1); idle(3);
        chk("err_seq_clean", err_seen, 0);

        // Address skip 200->202 discards the frame
        fill(5); mem[100] = 999;
        stream(0, 200); stream(202, NB-1); idle(3);
        chk("err_seq_skip", err_seen, 1);

        // Peak at SEARCH_HI; right neighbour just outside the window
        fill(0); mem[1023] = 77; mem[1024] = 65535; mem[1] = 65535;
        push(1023, 77, 3, 0, 65535);
        stream(0, NB-1); idle(3);

        // All-zero frame held under backpressure while two more frames arrive
        m_peak_tready = 1'b0;
        fill(0);
        push(LO, 0, 4, 0, 0);
        stream(0, NB-1);
        fill(9); mem[500] = 1234;
        stream(0, NB-1); stream(0, NB-1); idle(2);
        chk("hold_tvalid", int'(m_peak_tvalid), 1);
        chk("drop_cnt_two", int'(drop_cnt), 2);
        m_peak_tready = 1'b1;
        idle(3);
        chk("after_handshake_tvalid", int'(m_peak_tvalid), 0);

        fill(3); mem[2] = 4;
        push(2, 4, 5, 3, 3);
        stream(0, NB-1); idle(3);

        // Reset mid-scan clears everything
        fill(7);
        stream(0, 600);
        @(posedge aclk); #1;
        s_magni_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk_zero_outputs("midscan_reset");
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(2);

        fill(7); mem[700] = 8;
        push(700, 8, 0, 7, 7);
        stream(0, NB-1); idle(3);

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 200) begin
            @(posedge aclk);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
        chk("err_seq_total", err_seen, 1);
        chk("final_drop_cnt", int'(drop_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
